// File: rtl/topk_argmax_layer.sv
// Streaming top-K classifier head: ranks one score per beat, presents the K best per frame.
// Build option: define TOPK_SIGNED_EN to rank scores as two's complement instead of unsigned.
module topk_argmax_layer #(
   parameter int BIT_SIZE      = 8,
   parameter int NUM_CLASSES   = 10,
   parameter int TOP_K         = 3,
   parameter bit REVERSE_ORDER = 1'b1,
   localparam int IDX_W        = ($clog2(NUM_CLASSES) < 1) ? 1 : $clog2(NUM_CLASSES)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [BIT_SIZE-1:0]       in_data,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [TOP_K*IDX_W-1:0]    out_class,
   output logic [TOP_K*BIT_SIZE-1:0] out_score,
   output logic                      out_frame_err
);

   localparam int CNT_W = $clog2(TOP_K + 1);
   localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(NUM_CLASSES - 1);

   typedef enum logic {SCAN, HOLD} state_t;

   state_t                            state_q;
   logic [IDX_W-1:0]                  pos_q;
   logic [TOP_K-1:0]                  vld_q, vld_d;
   logic [TOP_K-1:0][BIT_SIZE-1:0]    score_q, score_d;
   logic [TOP_K-1:0][IDX_W-1:0]       lpos_q, lpos_d;
   logic [TOP_K-1:0][IDX_W-1:0]       class_d;
   logic                              frame_err_q, frame_err_d;
   logic [TOP_K*IDX_W-1:0]            out_class_q;
   logic [TOP_K*BIT_SIZE-1:0]         out_score_q;
   logic                              out_err_q;
   logic [TOP_K-1:0]                  hit;
   logic [CNT_W-1:0]                  ins_p;
   logic                              accept;
   logic                              last_pos;

   function automatic logic score_ge(input logic [BIT_SIZE-1:0] a, input logic [BIT_SIZE-1:0] b);
`ifdef TOPK_SIGNED_EN
      return $signed(a) >= $signed(b);
`else
      return a >= b;
`endif
   endfunction

   assign in_ready      = rst && (state_q == SCAN);
   assign out_valid     = (state_q == HOLD);
   assign out_class     = out_class_q;
   assign out_score     = out_score_q;
   assign out_frame_err = out_err_q;

   assign accept      = in_valid && in_ready;
   assign last_pos    = (pos_q == LAST_POS);
   assign frame_err_d = frame_err_q | (accept & (in_last != last_pos));

   // Insertion point: entries that tie with the new score stay ahead of it.
   always_comb begin
      ins_p = '0;
      for (int k = 0; k < TOP_K; k++) begin
         ins_p = ins_p + CNT_W'(hit[k]);
      end
   end

   generate
      for (genvar gi = 0; gi < TOP_K; gi++) begin : g_slot
         logic ins_here;
         logic shift_in;

         assign hit[gi]  = vld_q[gi] && score_ge(score_q[gi], in_data);
         assign ins_here = (ins_p == CNT_W'(gi));
         assign shift_in = (ins_p < CNT_W'(gi));

         if (gi == 0) begin : g_head
            assign vld_d[gi]   = ins_here ? 1'b1    : vld_q[gi];
            assign score_d[gi] = ins_here ? in_data : score_q[gi];
            assign lpos_d[gi]  = ins_here ? pos_q   : lpos_q[gi];
         end else begin : g_tail
            assign vld_d[gi]   = ins_here ? 1'b1    : shift_in ? vld_q[gi-1]   : vld_q[gi];
            assign score_d[gi] = ins_here ? in_data : shift_in ? score_q[gi-1] : score_q[gi];
            assign lpos_d[gi]  = ins_here ? pos_q   : shift_in ? lpos_q[gi-1]  : lpos_q[gi];
         end

         assign class_d[gi] = REVERSE_ORDER ? (LAST_POS - lpos_d[gi]) : lpos_d[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= SCAN;
         pos_q       <= '0;
         vld_q       <= '0;
         score_q     <= '0;
         lpos_q      <= '0;
         frame_err_q <= 1'b0;
         out_class_q <= '0;
         out_score_q <= '0;
         out_err_q   <= 1'b0;
      end else begin
         case (state_q)
            SCAN: begin
               if (accept) begin
                  vld_q       <= vld_d;
                  score_q     <= score_d;
                  lpos_q      <= lpos_d;
                  frame_err_q <= frame_err_d;
                  // Frame length is fixed; in_last only feeds the error flag.
                  if (last_pos) begin
                     pos_q       <= '0;
                     state_q     <= HOLD;
                     out_class_q <= class_d;
                     out_score_q <= score_d;
                     out_err_q   <= frame_err_d;
                  end else begin
                     pos_q <= pos_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  vld_q       <= '0;
                  frame_err_q <= 1'b0;
                  state_q     <= SCAN;
               end
            end
            default: state_q <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_topk_argmax_layer.sv
// Directed bench for topk_argmax_layer (default parameters, 10 classes, top-3).
module tb_topk_argmax_layer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_class;
   logic [23:0] out_score;
   logic        out_frame_err;

   int tests = 0;
   int fails = 0;

   logic [7:0] vec_a [10];
   logic [7:0] vec_z [10];
   logic [7:0] vec_s [10];
   logic [7:0] vec_f [10];

   always #5 clk = ~clk;

   topk_argmax_layer dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_class     (out_class),
      .out_score     (out_score),
      .out_frame_err (out_frame_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Sends one frame; in_last marks beat last_at, an idle gap of 2 cycles follows beat gap_at.
   task automatic run_frame(input logic [7:0] v [10], input int last_at, input int gap_at);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = v[i];
         in_last  = (i == last_at);
         if (i == 9) check("pre_last_out_valid", {31'b0, out_valid}, 32'd0);
         @(posedge clk); #1;
         if (i == gap_at) begin
            in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [11:0] cls, input logic [23:0] sc,
                               input logic err);
      $display("[TB] %s: out_valid=%b class=%h score=%h frame_err=%b", tag, out_valid, out_class,
               out_score, out_frame_err);
      check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
      check({tag, "_class"}, {20'b0, out_class}, {20'b0, cls});
      check({tag, "_score"}, {8'b0, out_score}, {8'b0, sc});
      check({tag, "_err"}, {31'b0, out_frame_err}, {31'b0, err});
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_post_valid"}, {31'b0, out_valid}, 32'd0);
      check({tag, "_post_ready"}, {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      vec_a = '{8'd5, 8'd80, 8'd12, 8'd80, 8'd3, 8'd200, 8'd0, 8'd7, 8'd1, 8'd9};
      vec_z = '{default: 8'd0};
      vec_s = '{8'hFF, 8'h01, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
      vec_f = '{default: 8'hFF};

      rst = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", {31'b0, in_ready}, 32'd0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_class", {20'b0, out_class}, 32'd0);
      check("rst_score", {8'b0, out_score}, 32'd0);
      check("rst_err", {31'b0, out_frame_err}, 32'd0);
      rst = 1'b1;
      #1;
      check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

      // Mixed values with a mid-frame stall; result checked the cycle after the last beat.
      run_frame(vec_a, 9, 4);
      check_result("basic", 12'h684, 24'h5050C8, 1'b0);

      // Hold the result for 5 cycles while a beat is offered; it must not be taken.
      in_valid = 1'b1; in_data = vec_a[0]; in_last = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("stall_valid", {31'b0, out_valid}, 32'd1);
         check("stall_class", {20'b0, out_class}, 32'h684);
         check("stall_score", {8'b0, out_score}, 32'h5050C8);
         check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      end
      handshake("stall");
      check("held_class", {20'b0, out_class}, 32'h684);
      // Beat 0 is accepted on this edge, the rest follow.
      @(posedge clk); #1;
      for (int i = 1; i < 10; i++) begin
         in_data = vec_a[i];
         in_last = (i == 9);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0;
      check_result("after_stall", 12'h684, 24'h5050C8, 1'b0);
      handshake("after_stall");

      run_frame(vec_z, 9, -1);
      check_result("zeros", 12'h789, 24'h000000, 1'b0);
      handshake("zeros");

      run_frame(vec_s, 9, -1);
`ifdef TOPK_SIGNED_EN
      check_result("sign", 12'h798, 24'h80FF01, 1'b0);
`else
      check_result("sign", 12'h679, 24'h8080FF, 1'b0);
`endif
      handshake("sign");

      // Early in_last: still ten beats, error flagged.
      run_frame(vec_a, 6, -1);
      check_result("early_last", 12'h684, 24'h5050C8, 1'b1);
      handshake("early_last");

      run_frame(vec_a, 9, -1);
      check_result("clean_after_err", 12'h684, 24'h5050C8, 1'b0);
      handshake("clean_after_err");

      // Reset after 4 beats of 0xFF, then a full frame must rank only its own values.
      in_valid = 1'b1; in_data = vec_f[0]; in_last = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
      rst = 1'b1;
      #1;
      run_frame(vec_a, 9, -1);
      check_result("after_rst", 12'h684, 24'h5050C8, 1'b0);
      handshake("after_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
